// File: rtl/arc4_seq_pkg.sv
// Shared types and defaults for the ARC4 decryption sequencer.
package arc4_seq_pkg;

  localparam int DEF_KEY_W  = 24;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_INIT = 2'd1;
  localparam logic [1:0] PH_KSA  = 2'd2;
  localparam logic [1:0] PH_PRGA = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START_INIT,
    ST_WAIT_INIT,
    ST_START_KSA,
    ST_WAIT_KSA,
    ST_START_PRGA,
    ST_WAIT_PRGA
  } seq_state_t;

endpackage

// File: rtl/arc4_seq_s_port_mux.sv
// S memory port mux: the active phase owns addr/wrdata/wren; idle drives zeros.
module s_port_mux
  import arc4_seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [1:0]        phase,
  input  logic [ADDR_W-1:0] init_s_addr,
  input  logic [DATA_W-1:0] init_s_wrdata,
  input  logic              init_s_wren,
  input  logic [ADDR_W-1:0] ksa_s_addr,
  input  logic [DATA_W-1:0] ksa_s_wrdata,
  input  logic              ksa_s_wren,
  input  logic [ADDR_W-1:0] prga_s_addr,
  input  logic [DATA_W-1:0] prga_s_wrdata,
  input  logic              prga_s_wren,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wrdata,
  output logic              s_wren
);

  // Select the owning sub-block; non-owners can never reach the write port.
  always_comb begin
    s_addr   = '0;
    s_wrdata = '0;
    s_wren   = 1'b0;
    case (phase)
      PH_INIT: begin
        s_addr   = init_s_addr;
        s_wrdata = init_s_wrdata;
        s_wren   = init_s_wren;
      end
      PH_KSA: begin
        s_addr   = ksa_s_addr;
        s_wrdata = ksa_s_wrdata;
        s_wren   = ksa_s_wren;
      end
      PH_PRGA: begin
        s_addr   = prga_s_addr;
        s_wrdata = prga_s_wrdata;
        s_wren   = prga_s_wren;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/arc4_seq.sv
// ARC4 decryption sequencer: runs init -> ksa -> prga via en/rdy handshakes
// and owns the S memory write/address port.
// Optional build macro ARC4_SEQ_CYCLE_CNT_EN adds a saturating busy-cycle counter output.
//
// state       | meaning
// ST_IDLE     | waiting for en, rdy=1
// ST_START_x  | waiting for x_rdy, then pulse x_en
// ST_WAIT_x   | waiting for x to go busy and come back ready
module arc4_seq
  import arc4_seq_pkg::*;
#(
  parameter int KEY_W  = DEF_KEY_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rdy,
  input  logic [KEY_W-1:0]  key,
  output logic [KEY_W-1:0]  key_q,
  output logic [1:0]        phase,
  output logic              init_en,
  output logic              ksa_en,
  output logic              prga_en,
  input  logic              init_rdy,
  input  logic              ksa_rdy,
  input  logic              prga_rdy,
  input  logic [ADDR_W-1:0] init_s_addr,
  input  logic [DATA_W-1:0] init_s_wrdata,
  input  logic              init_s_wren,
  input  logic [ADDR_W-1:0] ksa_s_addr,
  input  logic [DATA_W-1:0] ksa_s_wrdata,
  input  logic              ksa_s_wren,
  input  logic [ADDR_W-1:0] prga_s_addr,
  input  logic [DATA_W-1:0] prga_s_wrdata,
  input  logic              prga_s_wren,
`ifdef ARC4_SEQ_CYCLE_CNT_EN
  output logic [31:0]       cycles,
`endif
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wrdata,
  output logic              s_wren,
  input  logic [DATA_W-1:0] s_rddata
);

  seq_state_t state;
  logic       busy_seen;
  logic       unused_rddata;

  // s_rddata is wired straight to the sub-blocks outside this block.
  assign unused_rddata = ^s_rddata;

  // Sequencer FSM; a sub-block is done only once it has been seen busy after its start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rdy       <= 1'b1;
      init_en   <= 1'b0;
      ksa_en    <= 1'b0;
      prga_en   <= 1'b0;
      key_q     <= '0;
      phase     <= PH_IDLE;
      busy_seen <= 1'b0;
    end else begin
      init_en <= 1'b0;
      ksa_en  <= 1'b0;
      prga_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en && rdy) begin
            key_q <= key;
            rdy   <= 1'b0;
            phase <= PH_INIT;
            state <= ST_START_INIT;
          end
        end
        ST_START_INIT: begin
          if (init_rdy) begin
            init_en   <= 1'b1;
            busy_seen <= 1'b0;
            state     <= ST_WAIT_INIT;
          end
        end
        ST_WAIT_INIT: begin
          if (!init_rdy) begin
            busy_seen <= 1'b1;
          end else if (busy_seen) begin
            phase <= PH_KSA;
            state <= ST_START_KSA;
          end
        end
        ST_START_KSA: begin
          if (ksa_rdy) begin
            ksa_en    <= 1'b1;
            busy_seen <= 1'b0;
            state     <= ST_WAIT_KSA;
          end
        end
        ST_WAIT_KSA: begin
          if (!ksa_rdy) begin
            busy_seen <= 1'b1;
          end else if (busy_seen) begin
            phase <= PH_PRGA;
            state <= ST_START_PRGA;
          end
        end
        ST_START_PRGA: begin
          if (prga_rdy) begin
            prga_en   <= 1'b1;
            busy_seen <= 1'b0;
            state     <= ST_WAIT_PRGA;
          end
        end
        ST_WAIT_PRGA: begin
          if (!prga_rdy) begin
            busy_seen <= 1'b1;
          end else if (busy_seen) begin
            phase <= PH_IDLE;
            rdy   <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: begin
          phase <= PH_IDLE;
          rdy   <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ARC4_SEQ_CYCLE_CNT_EN
  // Busy-cycle counter: cleared on accept, counts every non-idle cycle, saturates, holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles <= '0;
    end else if (state == ST_IDLE) begin
      if (en && rdy) cycles <= '0;
    end else if (cycles != 32'hFFFF_FFFF) begin
      cycles <= cycles + 32'd1;
    end
  end
`endif

  s_port_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_s_port_mux (
    .phase         (phase),
    .init_s_addr   (init_s_addr),
    .init_s_wrdata (init_s_wrdata),
    .init_s_wren   (init_s_wren),
    .ksa_s_addr    (ksa_s_addr),
    .ksa_s_wrdata  (ksa_s_wrdata),
    .ksa_s_wren    (ksa_s_wren),
    .prga_s_addr   (prga_s_addr),
    .prga_s_wrdata (prga_s_wrdata),
    .prga_s_wren   (prga_s_wren),
    .s_addr        (s_addr),
    .s_wrdata      (s_wrdata),
    .s_wren        (s_wren)
  );

endmodule

// File: tb/tb_arc4_seq.sv
// Bench for arc4_seq: stub sub-blocks, random runs, scoreboard of key/latency per run.
module tb_arc4_seq;
  import arc4_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [23:0] key_q;
  logic [1:0]  phase;
  logic        init_en, ksa_en, prga_en;
  logic [2:0]  st_rdy;
  logic [7:0]  init_s_addr, ksa_s_addr, prga_s_addr;
  logic [7:0]  init_s_wrdata, ksa_s_wrdata, prga_s_wrdata;
  logic        init_s_wren, ksa_s_wren, prga_s_wren;
  logic [7:0]  s_addr, s_wrdata, s_rddata;
  logic        s_wren;
`ifdef ARC4_SEQ_CYCLE_CNT_EN
  logic [31:0] cycles;
`endif

  arc4_seq dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .rdy           (rdy),
    .key           (key),
    .key_q         (key_q),
    .phase         (phase),
    .init_en       (init_en),
    .ksa_en        (ksa_en),
    .prga_en       (prga_en),
    .init_rdy      (st_rdy[0]),
    .ksa_rdy       (st_rdy[1]),
    .prga_rdy      (st_rdy[2]),
    .init_s_addr   (init_s_addr),
    .init_s_wrdata (init_s_wrdata),
    .init_s_wren   (init_s_wren),
    .ksa_s_addr    (ksa_s_addr),
    .ksa_s_wrdata  (ksa_s_wrdata),
    .ksa_s_wren    (ksa_s_wren),
    .prga_s_addr   (prga_s_addr),
    .prga_s_wrdata (prga_s_wrdata),
    .prga_s_wren   (prga_s_wren),
`ifdef ARC4_SEQ_CYCLE_CNT_EN
    .cycles        (cycles),
`endif
    .s_addr        (s_addr),
    .s_wrdata      (s_wrdata),
    .s_wren        (s_wren),
    .s_rddata      (s_rddata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] key;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Stub sub-blocks: rdy drops the cycle after en and stays low st_low[i] cycles.
  logic [2:0] sub_en;
  int         st_cnt[3];
  int         st_low[3];
  assign sub_en = {prga_en, ksa_en, init_en};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_rdy <= 3'b111;
      for (int i = 0; i < 3; i++) st_cnt[i] <= 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sub_en[i]) begin
          st_rdy[i] <= 1'b0;
          st_cnt[i] <= st_low[i];
        end else if (!st_rdy[i]) begin
          if (st_cnt[i] <= 1) st_rdy[i] <= 1'b1;
          else st_cnt[i] <= st_cnt[i] - 1;
        end
      end
    end
  end

  // Stub S-port traffic: every sub-block writes at random, owner or not.
  always @(posedge clk) begin
    #2;
    init_s_addr   = 8'($urandom);
    init_s_wrdata = 8'($urandom);
    init_s_wren   = 1'($urandom_range(0, 1));
    ksa_s_addr    = 8'($urandom);
    ksa_s_wrdata  = 8'($urandom);
    ksa_s_wren    = 1'($urandom_range(0, 1));
    prga_s_addr   = 8'($urandom);
    prga_s_wrdata = 8'($urandom);
    prga_s_wren   = 1'($urandom_range(0, 1));
    s_rddata      = 8'($urandom);
  end

  // Monitor: S mux ownership, start-pulse order, key hold, completion scoreboard.
  int         run_cyc = 0;
  int         pidx = 0;
  logic       rdy_d = 1'b1;
  logic [16:0] exp_s;
  exp_t       e;

  always @(negedge clk) begin
    if (!rst_n) begin
      run_cyc = 0;
      pidx    = 0;
      rdy_d   = 1'b1;
    end else begin
      case (phase)
        2'd1:    exp_s = {init_s_wren, init_s_addr, init_s_wrdata};
        2'd2:    exp_s = {ksa_s_wren, ksa_s_addr, ksa_s_wrdata};
        2'd3:    exp_s = {prga_s_wren, prga_s_addr, prga_s_wrdata};
        default: exp_s = '0;
      endcase
      chk("s_mux", {s_wren, s_addr, s_wrdata}, exp_s);
      if (init_en || ksa_en || prga_en) begin
        if (exp_q.size() == 0) begin
          chk("stray_en", {init_en, ksa_en, prga_en}, 3'b000);
        end else begin
          chk("en_order", {init_en, ksa_en, prga_en, phase},
              {3'b100 >> pidx, 2'(pidx + 1)});
          pidx++;
        end
      end
      if (!rdy) begin
        run_cyc++;
        if (exp_q.size() > 0) chk("key_q_hold", key_q, exp_q[0].key);
      end else if (!rdy_d) begin
        if (exp_q.size() == 0) begin
          chk("spurious_done", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("latency", run_cyc, e.lat);
          chk("pulse_count", pidx, 3);
          chk("key_q_done", key_q, e.key);
          chk("phase_done", phase, 2'd0);
`ifdef ARC4_SEQ_CYCLE_CNT_EN
          chk("cycles", cycles, e.lat);
`endif
        end
        run_cyc = 0;
        pidx    = 0;
      end
      rdy_d = rdy;
    end
  end

  // Wait (bounded) at negedges until rdy is high.
  task automatic wait_rdy(input int limit);
    int n;
    n = 0;
    while (!rdy && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("rdy_wait", rdy, 1'b1);
  endtask

  // One request: program stub busy times, present en, then keep en high with a junk key.
  task automatic run_txn(input logic [23:0] k, input int l0, input int l1, input int l2,
                         input int hold);
    exp_t x;
    wait_rdy(5000);
    st_low[0] = l0;
    st_low[1] = l1;
    st_low[2] = l2;
    x.key = k;
    x.lat = 3 + (l0 + 2) + (l1 + 2) + (l2 + 2);
    exp_q.push_back(x);
    en  = 1'b1;
    key = k;
    @(negedge clk);
    key = 24'hFFFFFF;
    repeat (hold) @(negedge clk);
    en = 1'b0;
  endtask

  initial begin
    int n;
    en  = 1'b0;
    key = '0;
    for (int i = 0; i < 3; i++) st_low[i] = 1;
    repeat (3) @(negedge clk);
    chk("rst_rdy", rdy, 1'b1);
    chk("rst_phase", phase, 2'd0);
    chk("rst_en", {init_en, ksa_en, prga_en}, 3'b000);
    chk("rst_key_q", key_q, 24'h0);
    chk("rst_s_wren", s_wren, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Stub busy 256/768/32 cycles as seen by the sequencer; en held high with junk key.
    run_txn(24'h00033C, 254, 766, 30, 500);
    wait_rdy(2000);

    for (int t = 0; t < 30; t++) begin
      run_txn(24'($urandom), $urandom_range(1, 12), $urandom_range(1, 12),
              $urandom_range(1, 12), $urandom_range(0, 8));
    end
    wait_rdy(2000);
    repeat (3) @(negedge clk);

    // Abort in the middle of KSA.
    run_txn(24'h123456, 20, 40, 10, 0);
    n = 0;
    while (phase != 2'd2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("reach_ksa", phase, 2'd2);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_rdy", rdy, 1'b1);
    chk("abort_phase", phase, 2'd0);
    chk("abort_s_wren", s_wren, 1'b0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("post_abort_rdy", rdy, 1'b1);

    // Normal operation after the abort.
    run_txn(24'hA5A5A5, 3, 5, 7, 2);
    wait_rdy(2000);
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
